mem_access: RTL and testbench

Memory-access stage of the Dual-IS RV32IM pipeline, directly downstream of `execute`. It takes the ALU result and store data for one instruction at a time and runs a req/gnt/rvalid transaction on the data-memory port for loads and stores. It aligns and sign-extends load data, and presents a single-cycle writeback beat to the register-file write stage. Non-memory instructions pass through with one cycle of latency.

---
 rtl/dual_is_pkg.sv | 50 +++++
 rtl/mem_align.sv | 86 ++++++++
 rtl/mem_access.sv | 225 ++++++++++++++++++++++
 tb/tb_mem_access.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dual_is_pkg.sv
// ---------------------------------------------------------------------------
// dual_is_pkg
// Shared definitions for the Dual-IS RV32IM pipeline stages.
//   - RV32 opcode encodings used to classify instructions
//   - load/store funct3 encodings (width and signedness)
//   - mem_state_e : memory-access stage FSM state encoding
//   - helpers     : reserved funct3 detection, register-write classification
// ---------------------------------------------------------------------------
package dual_is_pkg;

    // RV32 base opcodes
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // Load/store width encodings
    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } mem_state_e;

    // Loads define B/H/W/BU/HU; stores only B/H/W.
    function automatic logic f3_reserved(input logic is_store, input logic [2:0] f3);
        if (is_store) begin
            return (f3 >= 3'd3);
        end
        return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    endfunction

    // Branches, fences and system ops never write the register file.
    function automatic logic writes_rd(input logic [6:0] op);
        return !((op == OP_BRANCH) || (op == OP_FENCE) || (op == OP_SYSTEM));
    endfunction

endpackage

// File: rtl/mem_align.sv
// ---------------------------------------------------------------------------
// mem_align
// Combinational lane logic for the memory-access stage.
//   funct3_i      : access width/signedness
//   is_store_i    : 1 = store, 0 = load
//   addr_i        : byte address (effective address)
//   store_data_i  : rs2 value for stores
//   rdata_i       : word returned by data memory
//   word_addr_o   : address with bits [1:0] cleared
//   be_o/wdata_o  : store byte enables and lane-replicated data
//   load_data_o   : extracted and sign/zero-extended load value
//   misaligned_o  : half with addr[0]=1 or word with addr[1:0]!=0
//   reserved_o    : funct3 has no defined meaning for this access type
// ---------------------------------------------------------------------------
module mem_align
    import dual_is_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic        is_store_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] word_addr_o,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o,
    output logic        misaligned_o,
    output logic        reserved_o
);

    logic [1:0]  off;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        reserved_o  = f3_reserved(is_store_i, funct3_i);
        word_addr_o = {addr_i[31:2], 2'b00};

        // Offset masked to natural alignment; only matters when the
        // misaligned access is allowed to proceed.
        off          = addr_i[1:0];
        misaligned_o = 1'b0;
        case (funct3_i[1:0])
            2'b01: begin
                off[0]       = 1'b0;
                misaligned_o = addr_i[0];
            end
            2'b10: begin
                off          = 2'b00;
                misaligned_o = |addr_i[1:0];
            end
            default: ;
        endcase
        if (reserved_o) begin
            misaligned_o = 1'b0;
        end

        // Store lanes
        case (funct3_i[1:0])
            2'b00: begin
                be_o    = 4'b0001 << off;
                wdata_o = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                be_o    = 4'b0011 << {off[1], 1'b0};
                wdata_o = {2{store_data_i[15:0]}};
            end
            default: begin
                be_o    = 4'hF;
                wdata_o = store_data_i;
            end
        endcase

        // Load lanes
        byte_sel = rdata_i[{off, 3'b000} +: 8];
        half_sel = rdata_i[{off[1], 4'b0000} +: 16];
        case (funct3_i)
            F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data_o = {24'h0, byte_sel};
            F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data_o = {16'h0, half_sel};
            default: load_data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// ---------------------------------------------------------------------------
// mem_access
// Memory-access stage of the Dual-IS RV32IM pipeline. Accepts one
// instruction at a time from execute, performs loads/stores over a
// req/gnt/rvalid data-memory port, and emits a one-cycle writeback beat.
//
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   ex_*                       : instruction from execute (valid/ready)
//   dmem_req/we/be/addr/wdata  : registered memory request
//   dmem_gnt/rvalid/rdata      : memory response
//   wb_valid/rd/data/we        : writeback beat
//   wb_misaligned              : misaligned-access trap flag
//   dbg_state                  : current FSM state (mem_state_e encoding)
//
// Configuration macro: MEM_ACCESS_MISALIGN_TRAP_EN
//   defined   : misaligned loads/stores issue no request and produce a
//               beat with wb_misaligned=1, wb_we=0
//   undefined : low address bits are masked to natural alignment and the
//               access proceeds; wb_misaligned stays 0
//
// Handshake: an instruction transfers on a rising edge where
// ex_valid & ex_ready; ex_ready is high only in IDLE. Memory requests are
// held (req/we/be/addr/wdata stable) until the edge where dmem_gnt is high;
// dmem_rvalid is honoured only in RESP, at least one cycle after the grant.
// ---------------------------------------------------------------------------
module mem_access
    import dual_is_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [6:0]        ex_opcode,
    input  logic [2:0]        ex_funct3,
    input  logic [4:0]        ex_rd,
    input  logic [31:0]       ex_aluout,
    input  logic [31:0]       ex_store_data,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [3:0]        dmem_be,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [31:0]       dmem_rdata,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_data,
    output logic              wb_we,
    output logic              wb_misaligned,
    output logic [1:0]        dbg_state
);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    mem_state_e state_q;

    // Captured instruction
    logic [6:0]  opcode_q;
    logic [2:0]  funct3_q;
    logic [4:0]  rd_q;
    logic [31:0] aluout_q;
    logic [31:0] sdata_q;

    // Registered outputs
    logic              dmem_req_q;
    logic              dmem_we_q;
    logic [3:0]        dmem_be_q;
    logic [ADDR_W-1:0] dmem_addr_q;
    logic [31:0]       dmem_wdata_q;
    logic              wb_valid_q;
    logic [4:0]        wb_rd_q;
    logic [31:0]       wb_data_q;
    logic              wb_we_q;
    logic              wb_misaligned_q;

    // Alignment inputs: live execute values while accepting, captured
    // values once a transaction is in flight.
    logic        in_idle;
    logic [2:0]  al_funct3;
    logic        al_is_store;
    logic [31:0] al_addr;
    logic [31:0] al_sdata;
    logic [31:0] al_word_addr;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_load_data;
    logic        al_misaligned;
    logic        al_reserved;

    logic        ex_is_mem;
    logic        trap;

    assign in_idle     = (state_q == IDLE);
    assign al_funct3   = in_idle ? ex_funct3 : funct3_q;
    assign al_is_store = in_idle ? (ex_opcode == OP_STORE) : (opcode_q == OP_STORE);
    assign al_addr     = in_idle ? ex_aluout : aluout_q;
    assign al_sdata    = in_idle ? ex_store_data : sdata_q;

    assign ex_is_mem   = (ex_opcode == OP_LOAD) || (ex_opcode == OP_STORE);
    assign trap        = TRAP_EN && al_misaligned;

    mem_align u_align (
        .funct3_i     (al_funct3),
        .is_store_i   (al_is_store),
        .addr_i       (al_addr),
        .store_data_i (al_sdata),
        .rdata_i      (dmem_rdata),
        .word_addr_o  (al_word_addr),
        .be_o         (al_be),
        .wdata_o      (al_wdata),
        .load_data_o  (al_load_data),
        .misaligned_o (al_misaligned),
        .reserved_o   (al_reserved)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            opcode_q        <= '0;
            funct3_q        <= '0;
            rd_q            <= '0;
            aluout_q        <= '0;
            sdata_q         <= '0;
            dmem_req_q      <= 1'b0;
            dmem_we_q       <= 1'b0;
            dmem_be_q       <= '0;
            dmem_addr_q     <= '0;
            dmem_wdata_q    <= '0;
            wb_valid_q      <= 1'b0;
            wb_rd_q         <= '0;
            wb_data_q       <= '0;
            wb_we_q         <= 1'b0;
            wb_misaligned_q <= 1'b0;
        end else begin
            // Writeback is a single-cycle pulse.
            wb_valid_q      <= 1'b0;
            wb_misaligned_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (ex_valid) begin
                        opcode_q <= ex_opcode;
                        funct3_q <= ex_funct3;
                        rd_q     <= ex_rd;
                        aluout_q <= ex_aluout;
                        sdata_q  <= ex_store_data;

                        if (ex_is_mem) begin
                            if (al_reserved || trap) begin
                                // No memory access; report completion next cycle.
                                wb_valid_q      <= 1'b1;
                                wb_rd_q         <= ex_rd;
                                wb_data_q       <= '0;
                                wb_we_q         <= 1'b0;
                                wb_misaligned_q <= trap;
                            end else begin
                                dmem_req_q   <= 1'b1;
                                dmem_we_q    <= al_is_store;
                                dmem_be_q    <= al_is_store ? al_be : 4'hF;
                                dmem_addr_q  <= ADDR_W'(al_word_addr);
                                dmem_wdata_q <= al_is_store ? al_wdata : 32'h0;
                                state_q      <= REQ;
                            end
                        end else begin
                            wb_valid_q <= 1'b1;
                            wb_rd_q    <= ex_rd;
                            wb_data_q  <= ex_aluout;
                            wb_we_q    <= writes_rd(ex_opcode);
                        end
                    end
                end

                REQ: begin
                    // An rvalid coincident with the grant is not ours yet.
                    if (dmem_gnt) begin
                        dmem_req_q <= 1'b0;
                        if (opcode_q == OP_STORE) begin
                            wb_valid_q <= 1'b1;
                            wb_rd_q    <= rd_q;
                            wb_data_q  <= '0;
                            wb_we_q    <= 1'b0;
                            state_q    <= IDLE;
                        end else begin
                            state_q <= RESP;
                        end
                    end
                end

                RESP: begin
                    if (dmem_rvalid) begin
                        wb_valid_q <= 1'b1;
                        wb_rd_q    <= rd_q;
                        wb_data_q  <= al_load_data;
                        wb_we_q    <= 1'b1;
                        state_q    <= IDLE;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign ex_ready      = in_idle;
    assign dmem_req      = dmem_req_q;
    assign dmem_we       = dmem_we_q;
    assign dmem_be       = dmem_be_q;
    assign dmem_addr     = dmem_addr_q;
    assign dmem_wdata    = dmem_wdata_q;
    assign wb_valid      = wb_valid_q;
    assign wb_rd         = wb_rd_q;
    assign wb_data       = wb_data_q;
    assign wb_we         = wb_we_q;
    assign wb_misaligned = wb_misaligned_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_access.sv
// ---------------------------------------------------------------------------
// tb_mem_access
// Directed bench for mem_access: pass-through, loads of every width,
// stores with wait states, reserved funct3, misaligned word load, reset
// mid-transaction and back-to-back store/load.
// ---------------------------------------------------------------------------
module tb_mem_access;
    import dual_is_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic [4:0]  ex_rd;
    logic [31:0] ex_aluout;
    logic [31:0] ex_store_data;
    logic        dmem_req;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_we;
    logic        wb_misaligned;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access #(.ADDR_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_opcode     (ex_opcode),
        .ex_funct3     (ex_funct3),
        .ex_rd         (ex_rd),
        .ex_aluout     (ex_aluout),
        .ex_store_data (ex_store_data),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_be       (dmem_be),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_gnt      (dmem_gnt),
        .dmem_rvalid   (dmem_rvalid),
        .dmem_rdata    (dmem_rdata),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .wb_we         (wb_we),
        .wb_misaligned (wb_misaligned),
        .dbg_state     (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one instruction; returns 1 ns after the accepting edge.
    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] sd);
        int guard = 0;
        while (!ex_ready && guard < 20) begin
            step();
            guard++;
        end
        check_eq("ex_ready_before_issue", 32'(ex_ready), 32'd1);
        ex_valid      = 1'b1;
        ex_opcode     = op;
        ex_funct3     = f3;
        ex_rd         = rd;
        ex_aluout     = alu;
        ex_store_data = sd;
        step();
        ex_valid = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [31:0] addr, input logic [31:0] rdata, input int waits,
                           input logic [31:0] exp_addr, input logic [31:0] exp_data);
        issue(OP_LOAD, f3, rd, addr, 32'h0);
        check_eq({tag, "_req"},  32'(dmem_req), 32'd1);
        check_eq({tag, "_we"},   32'(dmem_we),  32'd0);
        check_eq({tag, "_be"},   32'(dmem_be),  32'hF);
        check_eq({tag, "_addr"}, dmem_addr,     exp_addr);
        for (int i = 0; i < waits; i++) begin
            step();
            check_eq({tag, "_req_hold"},  32'(dmem_req), 32'd1);
            check_eq({tag, "_addr_hold"}, dmem_addr,     exp_addr);
            check_eq({tag, "_busy"},      32'(ex_ready), 32'd0);
        end
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        check_eq({tag, "_req_drop"}, 32'(dmem_req), 32'd0);
        check_eq({tag, "_resp_busy"}, 32'(ex_ready), 32'd0);
        for (int i = 0; i < waits; i++) begin
            step();
            check_eq({tag, "_no_early_wb"}, 32'(wb_valid), 32'd0);
        end
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
        step();
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;
        check_eq({tag, "_wb_valid"}, 32'(wb_valid), 32'd1);
        check_eq({tag, "_wb_data"},  wb_data,       exp_data);
        check_eq({tag, "_wb_we"},    32'(wb_we),    32'd1);
        check_eq({tag, "_wb_rd"},    32'(wb_rd),    32'(rd));
        check_eq({tag, "_ready"},    32'(ex_ready), 32'd1);
    endtask

    task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] sd, input int waits, input logic [31:0] exp_addr,
                            input logic [3:0] exp_be, input logic [31:0] exp_wdata);
        issue(OP_STORE, f3, 5'd0, addr, sd);
        check_eq({tag, "_req"},   32'(dmem_req), 32'd1);
        check_eq({tag, "_we"},    32'(dmem_we),  32'd1);
        check_eq({tag, "_be"},    32'(dmem_be),  32'(exp_be));
        check_eq({tag, "_addr"},  dmem_addr,     exp_addr);
        check_eq({tag, "_wdata"}, dmem_wdata,    exp_wdata);
        for (int i = 0; i < waits; i++) begin
            step();
            check_eq({tag, "_req_hold"},   32'(dmem_req), 32'd1);
            check_eq({tag, "_addr_hold"},  dmem_addr,     exp_addr);
            check_eq({tag, "_be_hold"},    32'(dmem_be),  32'(exp_be));
            check_eq({tag, "_wdata_hold"}, dmem_wdata,    exp_wdata);
            check_eq({tag, "_busy"},       32'(ex_ready), 32'd0);
            check_eq({tag, "_no_wb"},      32'(wb_valid), 32'd0);
        end
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        check_eq({tag, "_wb_valid"}, 32'(wb_valid), 32'd1);
        check_eq({tag, "_wb_we"},    32'(wb_we),    32'd0);
        check_eq({tag, "_req_drop"}, 32'(dmem_req), 32'd0);
        check_eq({tag, "_ready"},    32'(ex_ready), 32'd1);
    endtask

    initial begin
        rst_n         = 1'b0;
        ex_valid      = 1'b0;
        ex_opcode     = '0;
        ex_funct3     = '0;
        ex_rd         = '0;
        ex_aluout     = '0;
        ex_store_data = '0;
        dmem_gnt      = 1'b0;
        dmem_rvalid   = 1'b0;
        dmem_rdata    = '0;
        repeat (2) step();

        // Reset state
        check_eq("rst_ex_ready", 32'(ex_ready),      32'd1);
        check_eq("rst_req",      32'(dmem_req),      32'd0);
        check_eq("rst_we",       32'(dmem_we),       32'd0);
        check_eq("rst_be",       32'(dmem_be),       32'd0);
        check_eq("rst_addr",     dmem_addr,          32'd0);
        check_eq("rst_wdata",    dmem_wdata,         32'd0);
        check_eq("rst_wb_valid", 32'(wb_valid),      32'd0);
        check_eq("rst_wb_data",  wb_data,            32'd0);
        check_eq("rst_wb_we",    32'(wb_we),         32'd0);
        check_eq("rst_wb_mis",   32'(wb_misaligned), 32'd0);
        check_eq("rst_state",    32'(dbg_state),     32'd0);
        rst_n = 1'b1;
        step();

        // ADDI pass-through
        issue(OP_OPIMM, 3'd0, 5'd5, 32'h0000_1234, 32'h0);
        check_eq("pt_wb_valid", 32'(wb_valid), 32'd1);
        check_eq("pt_wb_rd",    32'(wb_rd),    32'd5);
        check_eq("pt_wb_data",  wb_data,       32'h0000_1234);
        check_eq("pt_wb_we",    32'(wb_we),    32'd1);
        check_eq("pt_no_req",   32'(dmem_req), 32'd0);
        step();
        check_eq("pt_pulse",    32'(wb_valid), 32'd0);

        // Back-to-back pass-through, one per cycle
        ex_valid = 1'b1; ex_opcode = OP_OP; ex_funct3 = 3'd0; ex_rd = 5'd6; ex_aluout = 32'h1111_0001;
        step();
        check_eq("b2b_pt0_data", wb_data, 32'h1111_0001);
        ex_rd = 5'd7; ex_aluout = 32'h2222_0002;
        step();
        ex_valid = 1'b0;
        check_eq("b2b_pt1_valid", 32'(wb_valid), 32'd1);
        check_eq("b2b_pt1_data",  wb_data,       32'h2222_0002);
        check_eq("b2b_pt1_rd",    32'(wb_rd),    32'd7);
        step();
        check_eq("b2b_pt_idle",   32'(wb_valid), 32'd0);

        // Branch: beat without register write
        issue(OP_BRANCH, 3'd0, 5'd0, 32'h0000_0001, 32'h0);
        check_eq("br_wb_valid", 32'(wb_valid), 32'd1);
        check_eq("br_wb_we",    32'(wb_we),    32'd0);

        // Loads
        do_load("lb",  F3_B,  5'd8,  32'h0000_0103, 32'h80FF_FF7F, 0, 32'h0000_0100, 32'hFFFF_FF80);
        do_load("lbu", F3_BU, 5'd9,  32'h0000_0103, 32'h80FF_FF7F, 0, 32'h0000_0100, 32'h0000_0080);
        do_load("lb0", F3_B,  5'd10, 32'h0000_0100, 32'h80FF_FF7F, 1, 32'h0000_0100, 32'h0000_007F);
        do_load("lh",  F3_H,  5'd11, 32'h0000_0102, 32'h80FF_FF7F, 0, 32'h0000_0100, 32'hFFFF_80FF);
        do_load("lhu", F3_HU, 5'd12, 32'h0000_0100, 32'h80FF_FF7F, 0, 32'h0000_0100, 32'h0000_FF7F);

        // Stores
        do_store("sh", F3_H, 32'h0000_0202, 32'hABCD_1234, 3, 32'h0000_0200, 4'b1100, 32'h1234_1234);
        do_store("sb", F3_B, 32'h0000_0301, 32'h0000_00A5, 0, 32'h0000_0300, 4'b0010, 32'hA5A5_A5A5);
        do_store("sw", F3_W, 32'h0000_0400, 32'hDEAD_BEEF, 1, 32'h0000_0400, 4'hF,    32'hDEAD_BEEF);

        // Reserved load funct3: no access, beat with no write
        issue(OP_LOAD, 3'd3, 5'd13, 32'h0000_0100, 32'h0);
        check_eq("rsv_wb_valid", 32'(wb_valid), 32'd1);
        check_eq("rsv_wb_we",    32'(wb_we),    32'd0);
        check_eq("rsv_no_req",   32'(dmem_req), 32'd0);
        check_eq("rsv_ready",    32'(ex_ready), 32'd1);

        // Misaligned lw at 0x006
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        issue(OP_LOAD, F3_W, 5'd14, 32'h0000_0006, 32'h0);
        check_eq("mis_no_req",   32'(dmem_req),      32'd0);
        check_eq("mis_wb_valid", 32'(wb_valid),      32'd1);
        check_eq("mis_flag",     32'(wb_misaligned), 32'd1);
        check_eq("mis_wb_we",    32'(wb_we),         32'd0);
`else
        do_load("lw_mis", F3_W, 5'd14, 32'h0000_0006, 32'h1122_3344, 0, 32'h0000_0004, 32'h1122_3344);
        check_eq("mis_flag_tied", 32'(wb_misaligned), 32'd0);
`endif

        // Reset while in REQ: request drops without a clock edge
        issue(OP_LOAD, F3_W, 5'd15, 32'h0000_0700, 32'h0);
        check_eq("rreq_req_up", 32'(dmem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rreq_req_drop", 32'(dmem_req),  32'd0);
        check_eq("rreq_state",    32'(dbg_state), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Reset while in RESP, then a stray rvalid
        issue(OP_LOAD, F3_W, 5'd16, 32'h0000_0800, 32'h0);
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        check_eq("rresp_state", 32'(dbg_state), 32'(RESP));
        rst_n = 1'b0;
        #1;
        check_eq("rresp_req",   32'(dmem_req),  32'd0);
        check_eq("rresp_ready", 32'(ex_ready),  32'd1);
        step();
        rst_n = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h5555_AAAA;
        step();
        dmem_rvalid = 1'b0;
        check_eq("stray_rvalid_wb0", 32'(wb_valid), 32'd0);
        step();
        check_eq("stray_rvalid_wb1", 32'(wb_valid), 32'd0);

        // Back-to-back sw then lw with 2 wait states
        do_store("b2b_sw", F3_W, 32'h0000_0500, 32'hCAFE_F00D, 2, 32'h0000_0500, 4'hF, 32'hCAFE_F00D);
        do_load("b2b_lw", F3_W, 5'd17, 32'h0000_0504, 32'h0BAD_C0DE, 2, 32'h0000_0504, 32'h0BAD_C0DE);
        step();
        check_eq("final_wb_pulse", 32'(wb_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
